// File: rtl/instr_seq_pkg.sv
// Shared types for the instruction sequencer: opcodes, FSM states, ALU codes
// and the decoded control word passed from op_decode to the FSM.
package instr_seq_pkg;

    // Control-word fields are sized generously and narrowed at the use site,
    // so a single package type serves every parameterisation.
    localparam int IDX_W_MAX = 8;
    localparam int ALU_W_MAX = 8;

    typedef enum logic [7:0] {
        OP_NOP     = 8'd0,
        OP_LOAD    = 8'd1,
        OP_MOV     = 8'd2,
        OP_ADD     = 8'd3,
        OP_READOUT = 8'd4,
        OP_SUB     = 8'd5,
        OP_AND     = 8'd6,
        OP_OR      = 8'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_READOUT
    } state_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    typedef struct packed {
        logic [IDX_W_MAX-1:0] rs1_sel;
        logic [IDX_W_MAX-1:0] rs2_sel;
        logic [ALU_W_MAX-1:0] alu_op;
        logic                 wb_sel;
        logic                 writes_rd;
        logic                 is_readout;
        logic                 is_nop;
        logic                 illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_sequencer_op_decode.sv
// Combinational opcode classifier: maps an opcode and source indices to the
// control word consumed by the sequencer FSM.
module op_decode
    import instr_seq_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 3
) (
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [IDX_W_MAX-1:0] rs1,
    input  logic [IDX_W_MAX-1:0] rs2,
    output ctrl_t                ctrl
);

    function automatic logic [ALU_W_MAX-1:0] alu_code(input logic [2:0] code);
        return ALU_W_MAX'(ALU_OP_W'(code));
    endfunction

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a field unassigned, which would otherwise infer a latch.
        ctrl            = '0;
        ctrl.rs1_sel    = rs1;
        ctrl.rs2_sel    = rs2;
        case (opcode)
            OPCODE_W'(OP_NOP):     ctrl.is_nop = 1'b1;
            OPCODE_W'(OP_LOAD):    begin ctrl.writes_rd = 1'b1; ctrl.wb_sel = 1'b1; end
            OPCODE_W'(OP_MOV):     begin ctrl.writes_rd = 1'b1; ctrl.alu_op = alu_code(ALU_PASS); end
            OPCODE_W'(OP_ADD):     begin ctrl.writes_rd = 1'b1; ctrl.alu_op = alu_code(ALU_ADD); end
            OPCODE_W'(OP_READOUT): ctrl.is_readout = 1'b1;
            OPCODE_W'(OP_SUB):     begin ctrl.writes_rd = 1'b1; ctrl.alu_op = alu_code(ALU_SUB); end
            OPCODE_W'(OP_AND):     begin ctrl.writes_rd = 1'b1; ctrl.alu_op = alu_code(ALU_AND); end
            OPCODE_W'(OP_OR):      begin ctrl.writes_rd = 1'b1; ctrl.alu_op = alu_code(ALU_OR); end
            default:               ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle handshaked sequencer driving register-file and ALU controls
// through DECODE/EXECUTE/WRITEBACK, with back-pressured READOUT.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int OPCODE_W  = 6,
    parameter int NUM_REGS  = 4,
    parameter int REG_IDX_W = $clog2(NUM_REGS),
    parameter int ALU_OP_W  = 3,
    parameter int CNT_W     = 16,
    localparam int INSTR_W  = OPCODE_W + 3 * REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr,
    output logic [REG_IDX_W-1:0] rs1_sel,
    output logic [REG_IDX_W-1:0] rs2_sel,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 wb_sel,
    output logic [NUM_REGS-1:0]  reg_we,
    output logic                 out_valid,
    output logic [REG_IDX_W-1:0] out_sel,
    input  logic                 out_ready,
    output logic                 illegal_op,
    output logic                 busy,
    output logic [CNT_W-1:0]     retired_cnt
);

    state_e               state;
    logic [INSTR_W-1:0]   instr_q;
    logic [INSTR_W-1:0]   dec_word;
    logic [REG_IDX_W-1:0] dec_rd;
    logic [REG_IDX_W-1:0] q_rd;
    logic                 bad_op;
    ctrl_t                dec;

    // Outputs are registered, so IDLE decodes the incoming word to raise
    // illegal_op on the DECODE cycle; afterwards only the latched copy counts.
    assign dec_word = (state == ST_IDLE) ? instr : instr_q;
    assign dec_rd   = dec_word[3*REG_IDX_W-1 -: REG_IDX_W];
    assign q_rd     = instr_q[3*REG_IDX_W-1 -: REG_IDX_W];
    assign bad_op   = dec.illegal || ({1'b0, dec_rd} >= (REG_IDX_W+1)'(NUM_REGS));

    op_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_op_decode (
        .opcode (dec_word[INSTR_W-1 -: OPCODE_W]),
        .rs1    (IDX_W_MAX'(dec_word[2*REG_IDX_W-1 -: REG_IDX_W])),
        .rs2    (IDX_W_MAX'(dec_word[REG_IDX_W-1:0])),
        .ctrl   (dec)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            instr_q     <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            rs1_sel     <= '0;
            rs2_sel     <= '0;
            alu_op      <= '0;
            wb_sel      <= 1'b0;
            reg_we      <= '0;
            out_valid   <= 1'b0;
            out_sel     <= '0;
            illegal_op  <= 1'b0;
            retired_cnt <= '0;
        end else begin
            illegal_op <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instr;
                        state       <= ST_DECODE;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                        illegal_op  <= bad_op;
                    end
                end
                ST_DECODE: begin
                    if (bad_op) begin
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else if (dec.is_nop) begin
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        retired_cnt <= retired_cnt + CNT_W'(1);
                    end else if (dec.is_readout) begin
                        state     <= ST_READOUT;
                        out_valid <= 1'b1;
                        out_sel   <= REG_IDX_W'(dec.rs1_sel);
                    end else if (dec.writes_rd) begin
                        state   <= ST_EXECUTE;
                        rs1_sel <= REG_IDX_W'(dec.rs1_sel);
                        rs2_sel <= REG_IDX_W'(dec.rs2_sel);
                        alu_op  <= ALU_OP_W'(dec.alu_op);
                        wb_sel  <= dec.wb_sel;
                    end else begin
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                ST_EXECUTE: begin
                    state  <= ST_WRITEBACK;
                    reg_we <= NUM_REGS'(1) << q_rd;
                end
                ST_WRITEBACK: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                    rs1_sel     <= '0;
                    rs2_sel     <= '0;
                    alu_op      <= '0;
                    wb_sel      <= 1'b0;
                    reg_we      <= '0;
                    retired_cnt <= retired_cnt + CNT_W'(1);
                end
                ST_READOUT: begin
                    if (out_ready) begin
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                        out_valid   <= 1'b0;
                        out_sel     <= '0;
                        retired_cnt <= retired_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized checks of instr_sequencer against a cycle-level
// expectation model derived from the opcode table and per-class latencies.
module tb_instr_sequencer;

    localparam int OPCODE_W  = 6;
    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;
    localparam int ALU_OP_W  = 3;
    localparam int CNT_W     = 4;
    localparam int INSTR_W   = OPCODE_W + 3 * REG_IDX_W;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_W-1:0]   instr;
    logic [REG_IDX_W-1:0] rs1_sel;
    logic [REG_IDX_W-1:0] rs2_sel;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 wb_sel;
    logic [NUM_REGS-1:0]  reg_we;
    logic                 out_valid;
    logic [REG_IDX_W-1:0] out_sel;
    logic                 out_ready;
    logic                 illegal_op;
    logic                 busy;
    logic [CNT_W-1:0]     retired_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    instr_sequencer #(
        .OPCODE_W (OPCODE_W),
        .NUM_REGS (NUM_REGS),
        .ALU_OP_W (ALU_OP_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rs1_sel     (rs1_sel),
        .rs2_sel     (rs2_sel),
        .alu_op      (alu_op),
        .wb_sel      (wb_sel),
        .reg_we      (reg_we),
        .out_valid   (out_valid),
        .out_sel     (out_sel),
        .out_ready   (out_ready),
        .illegal_op  (illegal_op),
        .busy        (busy),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
        return 32'(exp_cnt % (1 << CNT_W));
    endfunction

    // Opcode table: legal?, nop?, readout?, alu code, write-back source.
    task automatic spec_op(input int op, output bit legal, output bit nop, output bit ro,
                           output int alu, output bit wb);
        legal = 1'b1; nop = 1'b0; ro = 1'b0; alu = 0; wb = 1'b0;
        case (op)
            0: nop = 1'b1;
            1: wb = 1'b1;
            2: alu = 4;
            3: alu = 0;
            4: ro = 1'b1;
            5: alu = 1;
            6: alu = 2;
            7: alu = 3;
            default: legal = 1'b0;
        endcase
    endtask

    // Starts at a falling edge with the DUT idle; returns at a falling edge
    // with the DUT idle again. "hold" keeps instr_valid high with junk while busy.
    task automatic run(input int op, input int rd, input int rs1, input int rs2,
                       input int stall, input bit hold);
        bit legal, nop, ro, wb;
        int alu;
        spec_op(op, legal, nop, ro, alu, wb);
        chk("accept_ready", 32'(instr_ready), 32'd1);
        instr       = {OPCODE_W'(op), REG_IDX_W'(rd), REG_IDX_W'(rs1), REG_IDX_W'(rs2)};
        instr_valid = 1'b1;
        @(negedge clk);
        instr       = INSTR_W'($urandom);
        instr_valid = hold;
        chk("dec_busy", 32'(busy), 32'd1);
        chk("dec_ready", 32'(instr_ready), 32'd0);
        chk("dec_illegal", 32'(illegal_op), 32'(!legal));
        chk("dec_reg_we", 32'(reg_we), 32'd0);
        if (!legal || nop) begin
            if (nop) exp_cnt++;
            @(negedge clk);
            instr_valid = 1'b0;
            chk("short_ready", 32'(instr_ready), 32'd1);
            chk("short_illegal", 32'(illegal_op), 32'd0);
            chk("short_cnt", 32'(retired_cnt), cnt_exp());
        end else if (ro) begin
            @(negedge clk);
            for (int i = 0; i <= stall; i++) begin
                out_ready = (i == stall);
                chk("ro_valid", 32'(out_valid), 32'd1);
                chk("ro_sel", 32'(out_sel), 32'(rs1));
                chk("ro_cnt", 32'(retired_cnt), cnt_exp());
                @(negedge clk);
            end
            out_ready   = 1'b0;
            instr_valid = 1'b0;
            exp_cnt++;
            chk("ro_done_valid", 32'(out_valid), 32'd0);
            chk("ro_done_busy", 32'(busy), 32'd0);
            chk("ro_done_cnt", 32'(retired_cnt), cnt_exp());
        end else begin
            @(negedge clk);
            chk("ex_alu", 32'(alu_op), 32'(alu));
            chk("ex_rs1", 32'(rs1_sel), 32'(rs1));
            chk("ex_rs2", 32'(rs2_sel), 32'(rs2));
            chk("ex_wb", 32'(wb_sel), 32'(wb));
            chk("ex_reg_we", 32'(reg_we), 32'd0);
            @(negedge clk);
            chk("wb_alu", 32'(alu_op), 32'(alu));
            chk("wb_wb", 32'(wb_sel), 32'(wb));
            chk("wb_reg_we", 32'(reg_we), 32'(1 << rd));
            @(negedge clk);
            instr_valid = 1'b0;
            exp_cnt++;
            chk("ret_ready", 32'(instr_ready), 32'd1);
            chk("ret_reg_we", 32'(reg_we), 32'd0);
            chk("ret_alu", 32'(alu_op), 32'd0);
            chk("ret_cnt", 32'(retired_cnt), cnt_exp());
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        out_ready   = 1'b0;
        instr       = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(retired_cnt), 32'd0);
        chk("rst_outs", 32'({reg_we, out_valid, illegal_op, alu_op, wb_sel}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(3, 2, 0, 1, 0, 1'b0);   // ADD
        run(1, 3, 2, 0, 0, 1'b1);   // LOAD
        run(5, 0, 3, 2, 0, 1'b0);   // SUB
        run(6, 1, 1, 3, 0, 1'b1);   // AND
        run(7, 2, 2, 2, 0, 1'b0);   // OR
        run(2, 1, 3, 0, 0, 1'b0);   // MOV
        run(4, 0, 1, 0, 5, 1'b1);   // READOUT with stall
        run(4, 0, 2, 0, 0, 1'b0);   // READOUT, ready at entry
        run(63, 1, 0, 0, 0, 1'b0);  // illegal opcode
        run(0, 0, 0, 0, 0, 1'b1);   // NOP

        // Reset during WRITEBACK aborts the instruction.
        instr       = {OPCODE_W'(3), REG_IDX_W'(1), REG_IDX_W'(0), REG_IDX_W'(0)};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_we", 32'(reg_we), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("abort_we", 32'(reg_we), 32'd0);
        chk("abort_cnt", 32'(retired_cnt), 32'd0);
        chk("abort_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);

        // Back-to-back NOPs with instr_valid held: one accept every 2 cycles.
        instr       = '0;
        instr_valid = 1'b1;
        for (int t = 0; t < 32; t++) begin
            chk("nop_ready", 32'(instr_ready), 32'(t % 2 == 0));
            chk("nop_cnt", 32'(retired_cnt), 32'((exp_cnt + t / 2) % (1 << CNT_W)));
            @(negedge clk);
        end
        instr_valid = 1'b0;
        exp_cnt += 16;
        chk("nop_wrap_cnt", 32'(retired_cnt), cnt_exp());
        @(negedge clk);

        for (int k = 0; k < 24; k++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op > 7) op = int'($urandom_range(8, 63));
            run(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
